// File: rtl/sram_bus_pkg.sv
// Shared types for the split even/odd SRAM bus controller: FSM state encoding
// and bank lane indices.
package sram_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    W1   = 3'd2,
    P2   = 3'd3,
    W2   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic LANE_EVEN = 1'b0;
  localparam logic LANE_ODD  = 1'b1;

endpackage

// File: rtl/sram_lane_steer.sv
// Combinational lane steering: maps {word, addr[0], phase} to bank enables,
// even-bank address increment, write-data lanes and read-byte placement.
module sram_lane_steer
  import sram_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      word,
  input  logic                      a0,
  input  logic                      drv_phase,
  input  logic                      cap_phase,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/2-1:0]   e_q,
  input  logic [DATA_WIDTH/2-1:0]   o_q,
  output logic                      e_en,
  output logic                      o_en,
  output logic                      e_inc,
  output logic [DATA_WIDTH/2-1:0]   e_din,
  output logic [DATA_WIDTH/2-1:0]   o_din,
  output logic [DATA_WIDTH/2-1:0]   rd_lo,
  output logic [DATA_WIDTH/2-1:0]   rd_hi,
  output logic                      lo_en,
  output logic                      hi_en
);

  localparam int B = DATA_WIDTH / 2;

  logic [B-1:0] w_lo;
  logic [B-1:0] w_hi;

  assign w_lo = wdata[B-1:0];
  assign w_hi = wdata[DATA_WIDTH-1:B];

  // Drive side: which banks strobe in the upcoming phase and with what data.
  always_comb begin
    e_en  = 1'b0;
    o_en  = 1'b0;
    e_inc = 1'b0;
    e_din = w_lo;
    o_din = w_lo;
    if (!word) begin
      if (a0 == LANE_ODD) o_en = 1'b1;
      else                e_en = 1'b1;
    end else if (a0 == LANE_EVEN) begin
      e_en  = 1'b1;
      o_en  = 1'b1;
      o_din = w_hi;
    end else if (!drv_phase) begin
      o_en  = 1'b1;
    end else begin
      e_en  = 1'b1;
      e_inc = 1'b1;
      e_din = w_hi;
    end
  end

  // Capture side: where the bytes returned in the current wait cycle land.
  always_comb begin
    rd_lo = e_q;
    rd_hi = o_q;
    lo_en = 1'b0;
    hi_en = 1'b0;
    if (!word) begin
      rd_lo = (a0 == LANE_ODD) ? o_q : e_q;
      rd_hi = '0;
      lo_en = 1'b1;
      hi_en = 1'b1;
    end else if (a0 == LANE_EVEN) begin
      lo_en = 1'b1;
      hi_en = 1'b1;
    end else if (!cap_phase) begin
      rd_lo = o_q;
      lo_en = 1'b1;
    end else begin
      rd_hi = e_q;
      hi_en = 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Master-side controller for split even/odd byte-wide SRAM banks.
// MISALIGN_SPLIT_EN: defined splits misaligned words in two phases; undefined aligns them and flags align_err.
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      we,
  input  logic                      word,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      ack,
  output logic                      busy,
  output logic                      e_cs,
  output logic                      e_wr,
  output logic                      e_oe,
  output logic [ADDR_WIDTH-2:0]     e_addr,
  output logic [DATA_WIDTH/2-1:0]   e_din,
  input  logic [DATA_WIDTH/2-1:0]   e_q,
  output logic                      o_cs,
  output logic                      o_wr,
  output logic                      o_oe,
  output logic [ADDR_WIDTH-2:0]     o_addr,
  output logic [DATA_WIDTH/2-1:0]   o_din,
  input  logic [DATA_WIDTH/2-1:0]   o_q,
`ifndef MISALIGN_SPLIT_EN
  output logic                      align_err,
`endif
  output logic [2:0]                dbg_state
);

  localparam int AB = ADDR_WIDTH - 1;
  localparam int B  = DATA_WIDTH / 2;

  state_t state, next_state;

  logic            we_q, word_q, a0_q, two_q;
  logic [AB-1:0]   abank_q;
  logic [DATA_WIDTH-1:0] wdata_q, rbuf;

  logic            accept, a0_in, two_in;
  logic            d_sel, d_we, d_word, d_a0;
  logic [AB-1:0]   d_abank;
  logic [DATA_WIDTH-1:0] d_wdata;

  logic            s_e_en, s_o_en, s_e_inc, s_lo_en, s_hi_en;
  logic [B-1:0]    s_e_din, s_o_din, s_rd_lo, s_rd_hi;

  logic            e_cs_d, e_wr_d, e_oe_d, o_cs_d, o_wr_d, o_oe_d;
  logic [AB-1:0]   e_addr_d, o_addr_d;
  logic [B-1:0]    e_din_d, o_din_d;
  logic            ack_d, busy_d;
  logic [DATA_WIDTH-1:0] rdata_d, rbuf_d, base, cap;

  assign accept = (state == IDLE) && req;

`ifdef MISALIGN_SPLIT_EN
  assign a0_in  = addr[0];
  assign two_in = word & addr[0];
`else
  assign a0_in  = addr[0] & ~word;
  assign two_in = 1'b0;
  logic align_err_d;
  assign align_err_d = align_err | (accept & word & addr[0]);
`endif

  // In IDLE the upcoming phase is driven from the live request, later from the latch.
  assign d_sel   = (state == IDLE);
  assign d_we    = d_sel ? we    : we_q;
  assign d_word  = d_sel ? word  : word_q;
  assign d_a0    = d_sel ? a0_in : a0_q;
  assign d_abank = d_sel ? addr[ADDR_WIDTH-1:1] : abank_q;
  assign d_wdata = d_sel ? wdata : wdata_q;

  assign dbg_state = state;

  sram_lane_steer #(.DATA_WIDTH(DATA_WIDTH)) u_steer (
    .word      (d_word),
    .a0        (d_a0),
    .drv_phase (next_state == P2),
    .cap_phase (state == W2),
    .wdata     (d_wdata),
    .e_q       (e_q),
    .o_q       (o_q),
    .e_en      (s_e_en),
    .o_en      (s_o_en),
    .e_inc     (s_e_inc),
    .e_din     (s_e_din),
    .o_din     (s_o_din),
    .rd_lo     (s_rd_lo),
    .rd_hi     (s_rd_hi),
    .lo_en     (s_lo_en),
    .hi_en     (s_hi_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      e_cs    <= 1'b0;
      e_wr    <= 1'b0;
      e_oe    <= 1'b0;
      e_addr  <= '0;
      e_din   <= '0;
      o_cs    <= 1'b0;
      o_wr    <= 1'b0;
      o_oe    <= 1'b0;
      o_addr  <= '0;
      o_din   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      rbuf    <= '0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      a0_q    <= 1'b0;
      two_q   <= 1'b0;
      abank_q <= '0;
      wdata_q <= '0;
`ifndef MISALIGN_SPLIT_EN
      align_err <= 1'b0;
`endif
    end else begin
      state   <= next_state;
      e_cs    <= e_cs_d;
      e_wr    <= e_wr_d;
      e_oe    <= e_oe_d;
      e_addr  <= e_addr_d;
      e_din   <= e_din_d;
      o_cs    <= o_cs_d;
      o_wr    <= o_wr_d;
      o_oe    <= o_oe_d;
      o_addr  <= o_addr_d;
      o_din   <= o_din_d;
      ack     <= ack_d;
      busy    <= busy_d;
      rdata   <= rdata_d;
      rbuf    <= rbuf_d;
`ifndef MISALIGN_SPLIT_EN
      align_err <= align_err_d;
`endif
      if (accept) begin
        we_q    <= we;
        word_q  <= word;
        a0_q    <= a0_in;
        two_q   <= two_in;
        abank_q <= addr[ADDR_WIDTH-1:1];
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = P1;
      P1:      next_state = W1;
      W1:      next_state = two_q ? P2 : DONE;
      P2:      next_state = W2;
      W2:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    e_cs_d   = (next_state == P1 || next_state == P2) && s_e_en;
    o_cs_d   = (next_state == P1 || next_state == P2) && s_o_en;
    e_wr_d   = e_cs_d & d_we;
    e_oe_d   = e_cs_d & ~d_we;
    o_wr_d   = o_cs_d & d_we;
    o_oe_d   = o_cs_d & ~d_we;
    e_addr_d = e_cs_d ? d_abank + AB'(s_e_inc) : e_addr;
    o_addr_d = o_cs_d ? d_abank : o_addr;
    e_din_d  = e_cs_d ? s_e_din : e_din;
    o_din_d  = o_cs_d ? s_o_din : o_din;
    ack_d    = (next_state == DONE);
    busy_d   = (next_state != IDLE);
    // Each access starts from a clear buffer; phase 2 keeps the phase-1 low byte.
    base     = (state == W1) ? '0 : rbuf;
    cap      = {s_hi_en ? s_rd_hi : base[DATA_WIDTH-1:B],
                s_lo_en ? s_rd_lo : base[B-1:0]};
    rbuf_d   = (state == W1 || state == W2) ? cap : rbuf;
    rdata_d  = ((state == W1 || state == W2) && next_state == DONE && !we_q) ? cap : rdata;
  end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Upstream master-side controller for the split even/odd byte-wide SRAM banks (sramE/sramO `ram` instances).
- Accepts 16-bit CPU/DMA bus requests (byte or word, any alignment) on a pulse/ack handshake.
- Drives the two banks' cs/wr/oe/addr/din and collects their 1-cycle-latency registered Q outputs into a 16-bit read word.

Parameters:
- ADDR_WIDTH, 17, byte address width; each bank address is ADDR_WIDTH-1 bits.
- DATA_WIDTH, 16, bus width; each bank is DATA_WIDTH/2 bits.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request pulse; accepted only when busy=0.
- we  in  1  1=write, 0=read; sampled with req.
- word  in  1  1=16-bit access, 0=byte access; sampled with req.
- addr  in  ADDR_WIDTH  byte address; sampled with req.
- wdata  in  DATA_WIDTH  write data; byte writes use [7:0].
- rdata  out  DATA_WIDTH  read data; valid while ack=1, held until next ack.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance until the ack cycle, inclusive.
- e_cs, e_wr, e_oe  out  1 each  even-bank strobes.
- e_addr  out  ADDR_WIDTH-1  even-bank address.
- e_din  out  DATA_WIDTH/2  even-bank write data.
- e_q  in  DATA_WIDTH/2  even-bank read data.
- o_cs, o_wr, o_oe, o_addr, o_din, o_q  same as the e_* set, for the odd bank.

Behaviour:
- Reset (async): state=IDLE; all strobes=0, ack=0, busy=0, rdata=0; bank addr/din=0.
- All bank-side outputs are registered.
- A bank phase is one cycle with cs=1, wr=we and oe=~we, followed by one cycle with strobes=0.
- On a read, the bank Q is captured at the end of that strobes=0 cycle.
- Request latched on the edge where req=1 and state=IDLE. req while busy=1 is ignored; no queueing.
- Phase split:
  - Byte access: one phase on bank addr[0] (0=even, 1=odd) at addr[ADDR_WIDTH-1:1].
  - Aligned word (addr[0]=0): one phase, both banks, same bank address. Even supplies [7:0], odd supplies [15:8].
  - Misaligned word (addr[0]=1): phase 1 on the odd bank at A=addr>>1 supplies [7:0]. Phase 2 on the even bank at A+1 supplies [15:8]. A+1 wraps modulo 2^(ADDR_WIDTH-1).
- FSM states: IDLE -> P1 (strobes) -> W1 (capture) -> [P2 -> W2 if misaligned word] -> DONE (ack=1) -> IDLE.
- Latency, counted in edges from the acceptance edge to the first edge with ack=1:
  - single-phase access: 3;
  - two-phase access: 5.
- Writes follow the same FSM so that timing is uniform.
- Byte read: rdata[15:8]=0.
- Write lanes: byte write drives wdata[7:0] on the selected bank. Word writes drive the lane matching the byte order above.
- A new req is accepted in the cycle after DONE (IDLE), giving back-to-back throughput of one access per 4 or 6 cycles.
- rst_n low mid-operation: strobes drop immediately and no ack is issued. A completed phase-1 write of a misaligned word is not undone.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined: misaligned word accesses split into two phases as above.
- Undefined: addr[0] is ignored for word accesses, which execute as the aligned word at addr&~1 (single phase). Sticky output align_err (1 bit, reset 0) sets on any misaligned word request and clears only on reset. The port exists only when the macro is undefined.

Decomposition:
- Package sram_bus_pkg: FSM state enum (IDLE, P1, W1, P2, W2, DONE) and lane index constants (LANE_EVEN=0, LANE_ODD=1).
- Sub-module sram_lane_steer: combinational mapping of {word, addr[0], phase} to per-bank cs, address and data lane, plus read-byte placement.

Test Plan:
- Byte read at addr=0x00011 (odd bank, bank addr 0x0008) with o_q=0x5A: exactly one o_cs pulse, e_cs never asserts; ack 3 edges after req; rdata=0x005A.
- Aligned word write addr=0x00100, wdata=0xBEEF: one cycle with e_cs=o_cs=1 at bank addr 0x0080, e_din=0xEF, o_din=0xBE; ack after 3 edges.
- Misaligned word read addr=0x00101 with odd[0x0080]=0x34, even[0x0081]=0x12: o_cs phase then e_cs phase; ack after 5 edges; rdata=0x1234.
- Wrap case: misaligned word read at addr=0x1FFFF touches odd[0xFFFF] then even[0x0000].
- Without MISALIGN_SPLIT_EN, the same addr=0x00101 request gives a single phase at bank addr 0x0080 and align_err=1.
- req pulsed during busy is ignored: exactly one ack.
- rst_n asserted in state P2: strobes=0 in the same cycle and no ack; after release, a new request completes normally.
